// File: rtl/ctrl_seq_p.sv
// -----------------------------------------------------------------------------
// ctrl_seq_p -- parametrised VeriRISC control sequencer
//
// Purpose
//   Steps the 8-phase instruction cycle (INST_ADDR .. STORE) and decodes the
//   IR opcode into the datapath strobes that drive the PC, ACC, memory and IR
//   enables. It also provides:
//   - opcodes wider than 3 bits, where values >= 8 are "ext" opcodes;
//   - memory wait states in INST_FETCH and OP_FETCH;
//   - a sticky HALTED state that is left with resume.
//
// Parameters
//   OPCODE_W  opcode width (>= 3). Values 0..7 use the opcode_t encodings.
//   MEM_WAIT  extra stall cycles in INST_FETCH and in OP_FETCH (0..15).
//
// Configuration macro
//   CTRL_ILLEGAL_EN
//     Defined:   an ext opcode in OP_ADDR pulses illegal and halt, and the
//                sequencer then enters HALTED.
//     Undefined: ext opcodes run as NOP, and illegal is tied to 0.
//
// Ports
//   clk        in   rising-edge clock
//   rst_       in   asynchronous assert, active-low reset
//   en         in   advance enable; when 0, state and wait counter hold
//   opcode     in   IR opcode field; held stable from IDLE to the end of the
//                   instruction
//   zero       in   ACC==0 flag
//   resume     in   leaves HALTED (ignored in every other state)
//   phase      out  current phase 0..7; 0 while HALTED
//   halted     out  1 while in HALTED
//   mem_rd     out  memory read strobe
//   load_ir    out  IR load
//   inc_pc     out  PC increment
//   load_ac    out  ACC load
//   load_pc    out  PC load (jump)
//   mem_wr     out  memory write strobe
//   halt       out  asserted in OP_ADDR on a HLT decode (one cycle when en=1)
//   illegal    out  asserted in OP_ADDR on an ext opcode (macro builds only)
//   state_dbg  out  raw FSM state (0..7 = phases, 8 = HALTED)
//
// Advance rule
//   en is a plain advance qualifier, not a handshake. A state transition or a
//   wait-counter update happens only on a rising clk edge where en=1. The
//   strobes always decode the state that is currently held, so a stalled phase
//   keeps its strobes asserted.
// -----------------------------------------------------------------------------
module ctrl_seq_p #(
  parameter int OPCODE_W = 3,
  parameter int MEM_WAIT = 0
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                en,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                resume,
  output logic [2:0]          phase,
  output logic                halted,
  output logic                mem_rd,
  output logic                load_ir,
  output logic                inc_pc,
  output logic                load_ac,
  output logic                load_pc,
  output logic                mem_wr,
  output logic                halt,
  output logic                illegal,
  output logic [3:0]          state_dbg
);

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  // Phase states share their encoding with the phase output.
  // HALTED sits outside the 3-bit phase range.
  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_t;

  localparam logic [3:0] MEM_WAIT_C = 4'(MEM_WAIT);

  state_t     state;
  logic [3:0] wait_cnt;

  // ---------------------------------------------------------------------------
  // Opcode classification
  // ---------------------------------------------------------------------------
  opcode_t op_t;
  logic    ext;       // opcode >= 8
  logic    ext_trap;  // an ext opcode that must halt the machine
  logic    is_hlt;
  logic    is_skz;
  logic    is_alu;    // ADD | AND | XOR | LDA
  logic    is_sto;
  logic    is_jmp;

  assign op_t = opcode_t'(opcode[2:0]);

  generate
    if (OPCODE_W > 3) begin : g_ext
      assign ext = |opcode[OPCODE_W-1:3];
    end else begin : g_no_ext
      assign ext = 1'b0;
    end
  endgenerate

  // Every named decode is qualified with !ext. Otherwise an ext opcode such as
  // 4'h8 would alias onto HLT through its low three bits.
  assign is_hlt = !ext && (op_t == HLT);
  assign is_skz = !ext && (op_t == SKZ);
  assign is_alu = !ext && ((op_t == ADD) || (op_t == AND) ||
                           (op_t == XOR) || (op_t == LDA));
  assign is_sto = !ext && (op_t == STO);
  assign is_jmp = !ext && (op_t == JMP);

`ifdef CTRL_ILLEGAL_EN
  assign ext_trap = ext;
  assign illegal  = (state == OP_ADDR) && ext;
`else
  assign ext_trap = 1'b0;
  assign illegal  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register and wait counter
  // ---------------------------------------------------------------------------
  // Each fetch phase loads wait_cnt on entry and holds the phase while
  // wait_cnt is non-zero. As a result, a fetch phase lasts MEM_WAIT+1
  // enabled cycles.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= INST_ADDR;
      wait_cnt <= 4'd0;
    end else if (en) begin
      case (state)
        INST_ADDR: begin
          state    <= INST_FETCH;
          wait_cnt <= MEM_WAIT_C;
        end
        INST_FETCH: begin
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
          else                  state    <= INST_LOAD;
        end
        INST_LOAD: state <= IDLE;
        IDLE:      state <= OP_ADDR;
        OP_ADDR: begin
          // The PC is incremented in this phase, so on resume the machine
          // continues at the instruction after the HLT.
          if (is_hlt || ext_trap) begin
            state <= HALTED;
          end else begin
            state    <= OP_FETCH;
            wait_cnt <= MEM_WAIT_C;
          end
        end
        OP_FETCH: begin
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
          else                  state    <= ALU_OP;
        end
        ALU_OP: state <= STORE;
        STORE:  state <= INST_ADDR;
        HALTED: begin
          if (resume) state <= INST_ADDR;
        end
        default: state <= INST_ADDR;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs. These depend only on the state register, so a reset
  // drops them asynchronously.
  // ---------------------------------------------------------------------------
  assign state_dbg = state;
  assign halted    = (state == HALTED);
  assign phase     = halted ? 3'd0 : state_dbg[2:0];

  // ---------------------------------------------------------------------------
  // Strobe decode
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    halt    = 1'b0;
    case (state)
      INST_FETCH: begin
        mem_rd = 1'b1;
      end
      INST_LOAD, IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = is_hlt || ext_trap;
      end
      OP_FETCH: begin
        mem_rd = is_alu;
      end
      ALU_OP: begin
        mem_rd  = is_alu;
        load_ac = is_alu;
        inc_pc  = is_skz && zero;
        load_pc = is_jmp;
      end
      STORE: begin
        mem_rd  = is_alu;
        load_ac = is_alu;
        inc_pc  = is_jmp;
        load_pc = is_jmp;
        mem_wr  = is_sto;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_seq_p.sv
// -----------------------------------------------------------------------------
// tb_ctrl_seq_p -- directed bench for ctrl_seq_p
//
// Two instances are used:
//   u_dut0  OPCODE_W=4, MEM_WAIT=0
//   u_dut1  OPCODE_W=3, MEM_WAIT=2
//
// The driver updates inputs 1 ns after each rising edge. For every cycle it
// pushes the hand-computed outputs expected in that cycle onto exp_q. The
// monitor pops exp_q on each falling edge and compares.
// -----------------------------------------------------------------------------
module tb_ctrl_seq_p;

  localparam int W = 27;  // {sel, step[9:0], state[3:0], phase[2:0], mask[8:0]}

  localparam logic [3:0] HLT = 4'd0, SKZ = 4'd1, ADD = 4'd2, AND = 4'd3,
                         XOR = 4'd4, LDA = 4'd5, STO = 4'd6, JMP = 4'd7;

  // Mask bit order: {halted, mem_rd, load_ir, inc_pc, load_ac, load_pc,
  //                  mem_wr, halt, illegal}
  localparam logic [8:0] M_0   = 9'h000, M_H  = 9'h100, M_RD = 9'h080,
                         M_IR  = 9'h040, M_INC = 9'h020, M_AC = 9'h010,
                         M_PC  = 9'h008, M_WR = 9'h004, M_HL = 9'h002,
                         M_IL  = 9'h001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_;

  // ---------------- DUT signals ----------------
  logic       en0, zero0, res0;
  logic [3:0] op0;
  logic [2:0] phase0;
  logic       halted0, mem_rd0, load_ir0, inc_pc0, load_ac0, load_pc0;
  logic       mem_wr0, halt0, illegal0;
  logic [3:0] st0;

  logic       en1, zero1, res1;
  logic [2:0] op1;
  logic [2:0] phase1;
  logic       halted1, mem_rd1, load_ir1, inc_pc1, load_ac1, load_pc1;
  logic       mem_wr1, halt1, illegal1;
  logic [3:0] st1;

  ctrl_seq_p #(.OPCODE_W(4), .MEM_WAIT(0)) u_dut0 (
    .clk(clk), .rst_(rst_), .en(en0), .opcode(op0), .zero(zero0),
    .resume(res0), .phase(phase0), .halted(halted0), .mem_rd(mem_rd0),
    .load_ir(load_ir0), .inc_pc(inc_pc0), .load_ac(load_ac0),
    .load_pc(load_pc0), .mem_wr(mem_wr0), .halt(halt0), .illegal(illegal0),
    .state_dbg(st0)
  );

  ctrl_seq_p #(.OPCODE_W(3), .MEM_WAIT(2)) u_dut1 (
    .clk(clk), .rst_(rst_), .en(en1), .opcode(op1), .zero(zero1),
    .resume(res1), .phase(phase1), .halted(halted1), .mem_rd(mem_rd1),
    .load_ir(load_ir1), .inc_pc(inc_pc1), .load_ac(load_ac1),
    .load_pc(load_pc1), .mem_wr(mem_wr1), .halt(halt1), .illegal(illegal1),
    .state_dbg(st1)
  );

  logic [15:0] act0, act1;
  assign act0 = {st0, phase0, halted0, mem_rd0, load_ir0, inc_pc0, load_ac0,
                 load_pc0, mem_wr0, halt0, illegal0};
  assign act1 = {st1, phase1, halted1, mem_rd1, load_ir1, inc_pc1, load_ac1,
                 load_pc1, mem_wr1, halt1, illegal1};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int step_no = 0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [15:0]  a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = e[26] ? act1 : act0;
      checks++;
      if (a !== e[15:0]) begin
        errors++;
        $display("FAIL step%0d dut%0d: got state=%0d phase=%0d strobes=%b, required state=%0d phase=%0d strobes=%b",
                 e[25:16], e[26], a[15:12], a[11:9], a[8:0],
                 e[15:12], e[11:9], e[8:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle: drive inputs to one DUT (the other is held with en=0) and
  // queue the outputs expected during this cycle.
  task automatic step(input bit sel, input logic r, input logic e,
                      input logic [3:0] op, input logic z, input logic res,
                      input logic [2:0] ph, input logic [8:0] m);
    logic [3:0] est;
    @(posedge clk);
    #1;
    rst_ = r;
    if (!sel) begin
      en0 = e; op0 = op; zero0 = z; res0 = res; en1 = 1'b0;
    end else begin
      en1 = e; op1 = op[2:0]; zero1 = z; res1 = res; en0 = 1'b0;
    end
    step_no++;
    est = m[8] ? 4'd8 : {1'b0, ph};
    exp_q.push_back({sel, step_no[9:0], est, ph, m});
  endtask

  // Phases 0..3. INST_FETCH lasts nw+1 cycles.
  task automatic fetch(input bit sel, input logic [3:0] op, input logic z,
                       input int nw);
    step(sel, 1, 1, op, z, 0, 3'd0, M_0);
    repeat (nw + 1) step(sel, 1, 1, op, z, 0, 3'd1, M_RD);
    step(sel, 1, 1, op, z, 0, 3'd2, M_RD | M_IR);
    step(sel, 1, 1, op, z, 0, 3'd3, M_RD | M_IR);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] alu_ops[2];
    logic [3:0] ext_ops[2];
    alu_ops[0] = AND; alu_ops[1] = XOR;
    ext_ops[0] = 4'hA; ext_ops[1] = 4'h8;
    rst_ = 1'b0;
    en0 = 1'b0; op0 = 4'd0; zero0 = 1'b0; res0 = 1'b0;
    en1 = 1'b0; op1 = 3'd0; zero1 = 1'b0; res1 = 1'b0;

    // Reset state.
    step(0, 0, 1, ADD, 0, 0, 3'd0, M_0);
    step(0, 0, 1, ADD, 0, 0, 3'd0, M_0);

    // ADD, no wait states.
    fetch(0, ADD, 0, 0);
    step(0, 1, 1, ADD, 0, 0, 3'd4, M_INC);
    step(0, 1, 1, ADD, 0, 0, 3'd5, M_RD);
    step(0, 1, 1, ADD, 0, 0, 3'd6, M_RD | M_AC);
    step(0, 1, 1, ADD, 0, 0, 3'd7, M_RD | M_AC);

    // SKZ with zero=1.
    fetch(0, SKZ, 1, 0);
    step(0, 1, 1, SKZ, 1, 0, 3'd4, M_INC);
    step(0, 1, 1, SKZ, 1, 0, 3'd5, M_0);
    step(0, 1, 1, SKZ, 1, 0, 3'd6, M_INC);
    step(0, 1, 1, SKZ, 1, 0, 3'd7, M_0);

    // SKZ with zero=0.
    fetch(0, SKZ, 0, 0);
    step(0, 1, 1, SKZ, 0, 0, 3'd4, M_INC);
    step(0, 1, 1, SKZ, 0, 0, 3'd5, M_0);
    step(0, 1, 1, SKZ, 0, 0, 3'd6, M_0);
    step(0, 1, 1, SKZ, 0, 0, 3'd7, M_0);

    // JMP.
    fetch(0, JMP, 0, 0);
    step(0, 1, 1, JMP, 0, 0, 3'd4, M_INC);
    step(0, 1, 1, JMP, 0, 0, 3'd5, M_0);
    step(0, 1, 1, JMP, 0, 0, 3'd6, M_PC);
    step(0, 1, 1, JMP, 0, 0, 3'd7, M_INC | M_PC);

    // Remaining ALU opcodes.
    for (int i = 0; i < 2; i++) begin
      fetch(0, alu_ops[i], 0, 0);
      step(0, 1, 1, alu_ops[i], 0, 0, 3'd4, M_INC);
      step(0, 1, 1, alu_ops[i], 0, 0, 3'd5, M_RD);
      step(0, 1, 1, alu_ops[i], 0, 0, 3'd6, M_RD | M_AC);
      step(0, 1, 1, alu_ops[i], 0, 0, 3'd7, M_RD | M_AC);
    end

    // STO: freeze phase 5 for 3 clocks, hold STORE, then reset mid-STORE.
    fetch(0, STO, 0, 0);
    step(0, 1, 1, STO, 0, 0, 3'd4, M_INC);
    repeat (3) step(0, 1, 0, STO, 0, 0, 3'd5, M_0);
    step(0, 1, 1, STO, 0, 0, 3'd5, M_0);
    step(0, 1, 1, STO, 0, 0, 3'd6, M_0);
    step(0, 1, 0, STO, 0, 0, 3'd7, M_WR);
    step(0, 1, 0, STO, 0, 0, 3'd7, M_WR);
    step(0, 0, 0, STO, 0, 0, 3'd0, M_0);
    step(0, 0, 1, STO, 0, 0, 3'd0, M_0);

    // HLT: halt pulse, sticky HALTED, en=0 blocks resume, then resume.
    fetch(0, HLT, 0, 0);
    step(0, 1, 1, HLT, 0, 0, 3'd4, M_INC | M_HL);
    repeat (5) step(0, 1, 1, HLT, 0, 0, 3'd0, M_H);
    step(0, 1, 0, HLT, 0, 1, 3'd0, M_H);
    step(0, 1, 1, HLT, 0, 1, 3'd0, M_H);

    // ADD with resume=1 outside HALTED (must be ignored).
    step(0, 1, 1, ADD, 0, 1, 3'd0, M_0);
    step(0, 1, 1, ADD, 0, 1, 3'd1, M_RD);
    step(0, 1, 1, ADD, 0, 1, 3'd2, M_RD | M_IR);
    step(0, 1, 1, ADD, 0, 1, 3'd3, M_RD | M_IR);
    step(0, 1, 1, ADD, 0, 1, 3'd4, M_INC);
    step(0, 1, 1, ADD, 0, 1, 3'd5, M_RD);
    step(0, 1, 1, ADD, 0, 1, 3'd6, M_RD | M_AC);
    step(0, 1, 1, ADD, 0, 1, 3'd7, M_RD | M_AC);

    // Ext opcodes 4'hA and 4'h8 (4'h8 must not alias to HLT).
    for (int i = 0; i < 2; i++) begin
      fetch(0, ext_ops[i], 0, 0);
`ifdef CTRL_ILLEGAL_EN
      step(0, 1, 1, ext_ops[i], 0, 0, 3'd4, M_INC | M_HL | M_IL);
      step(0, 1, 1, ext_ops[i], 0, 0, 3'd0, M_H);
      step(0, 1, 1, ext_ops[i], 0, 1, 3'd0, M_H);
`else
      step(0, 1, 1, ext_ops[i], 0, 0, 3'd4, M_INC);
      step(0, 1, 1, ext_ops[i], 0, 0, 3'd5, M_0);
      step(0, 1, 1, ext_ops[i], 0, 0, 3'd6, M_0);
      step(0, 1, 1, ext_ops[i], 0, 0, 3'd7, M_0);
`endif
    end

    // MEM_WAIT=2 instance, LDA: 3-cycle fetch phases, en=0 holds the counter.
    fetch(1, LDA, 0, 2);
    step(1, 1, 1, LDA, 0, 0, 3'd4, M_INC);
    step(1, 1, 1, LDA, 0, 0, 3'd5, M_RD);
    step(1, 1, 0, LDA, 0, 0, 3'd5, M_RD);
    step(1, 1, 1, LDA, 0, 0, 3'd5, M_RD);
    step(1, 1, 1, LDA, 0, 0, 3'd5, M_RD);
    step(1, 1, 1, LDA, 0, 0, 3'd6, M_RD | M_AC);
    step(1, 1, 1, LDA, 0, 0, 3'd7, M_RD | M_AC);
    step(1, 1, 1, LDA, 0, 0, 3'd0, M_0);

    // Drain the scoreboard and report.
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued entries, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
